reorder_buffer: RTL

- Circular in-order reorder buffer between the issue stage, the result bus (CDB) and the register file.
- Allocates a ROB id per issued instruction, which the issue stage passes to the register file as the dependency tag.
- Collects results and commits one instruction per cycle in program order, driving the register-file write port.
- Detects branch mispredictions at commit and broadcasts a pipeline-wide clear with the redirect PC.

---
 rtl/reorder_buffer_pkg.sv | 23 ++
 rtl/reorder_buffer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared ROB constants, the per-entry payload type and the misprediction test.
//   ROB_IDX_W : log2 of the ROB entry count (the shared ROB_INDEX_BIT constant)
//   ROB_DEPTH : entry count derived from ROB_IDX_W
//   REG_IDX_W : architectural register index width
package reorder_buffer_pkg;
  localparam int ROB_IDX_W = 3;
  localparam int ROB_DEPTH = 2 ** ROB_IDX_W;
  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic                 is_br;
    logic                 pred_jump;
    logic [31:0]          pc;
    logic [31:0]          value;
    logic                 jump;
    logic [31:0]          target;
  } rob_entry_t;

  function automatic logic mispredicted(input rob_entry_t e);
    return e.is_br && (e.jump != e.pred_jump);
  endfunction
endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order reorder buffer; allocates ids at issue, collects CDB
// results, commits one entry per cycle to the register file and flushes on a branch mispredict.
//   clk_in, rst_in (async, active-low), rdy_in (global stall when low)
//   issue_*   : instruction offered by issue; full / alloc_id report acceptance and its id
//   wb_*      : result bus write-back (value, actual branch outcome, redirect target)
//   qry_*     : two combinational operand lookups with same-cycle write-back bypass
//   set_value*: registered commit port toward the register file (id 0 = no write)
//   clear, clear_pc : registered one-cycle flush pulse and redirect PC
//   Optional ROB_DBG_COMMIT_EN adds dbg_commit / dbg_commit_addr (committed pc).
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_INDEX_BIT = ROB_IDX_W
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [REG_IDX_W-1:0]     issue_rd,
  input  logic                     issue_is_br,
  input  logic                     issue_pred_jump,
  input  logic [31:0]              issue_pc,
  output logic                     full,
  output logic [ROB_INDEX_BIT-1:0] alloc_id,
  input  logic                     wb_valid,
  input  logic [ROB_INDEX_BIT-1:0] wb_rob_id,
  input  logic [31:0]              wb_value,
  input  logic                     wb_jump,
  input  logic [31:0]              wb_target,
  input  logic [ROB_INDEX_BIT-1:0] qry_id1,
  input  logic [ROB_INDEX_BIT-1:0] qry_id2,
  output logic                     qry_ready1,
  output logic                     qry_ready2,
  output logic [31:0]              qry_val1,
  output logic [31:0]              qry_val2,
  output logic [REG_IDX_W-1:0]     set_value_id,
  output logic [31:0]              set_value,
  output logic [ROB_INDEX_BIT-1:0] set_value_rob_id,
  output logic                     clear,
  output logic [31:0]              clear_pc
`ifdef ROB_DBG_COMMIT_EN
  , output logic                   dbg_commit,
  output logic [31:0]              dbg_commit_addr
`endif
);
  localparam int DEPTH = 2 ** ROB_INDEX_BIT;

  rob_entry_t                 ent_q [DEPTH];
  rob_entry_t                 ent_d [DEPTH];
  logic [DEPTH-1:0]           busy_q, busy_d, ready_q, ready_d;
  logic [ROB_INDEX_BIT-1:0]   head_q, head_d, tail_q, tail_d;
  logic [ROB_INDEX_BIT:0]     count_q, count_d;
  logic [REG_IDX_W-1:0]       set_value_id_q, set_value_id_d;
  logic [31:0]                set_value_q, set_value_d, clear_pc_q, clear_pc_d;
  logic [ROB_INDEX_BIT-1:0]   set_value_rob_id_q, set_value_rob_id_d;
  logic                       clear_q, clear_d;
  logic                       do_issue, do_commit, do_flush;

  assign full       = count_q == (ROB_INDEX_BIT+1)'(DEPTH);
  assign alloc_id   = tail_q;
  assign do_commit  = rdy_in && busy_q[head_q] && ready_q[head_q];
  assign do_flush   = do_commit && mispredicted(ent_q[head_q]);
  // full is sampled at the start of the cycle, so a commit never makes room for a same-cycle issue
  assign do_issue   = rdy_in && issue_valid && !full && !do_flush;

  assign qry_ready1 = busy_q[qry_id1] && (ready_q[qry_id1] || (wb_valid && wb_rob_id == qry_id1));
  assign qry_ready2 = busy_q[qry_id2] && (ready_q[qry_id2] || (wb_valid && wb_rob_id == qry_id2));
  assign qry_val1   = (wb_valid && wb_rob_id == qry_id1) ? wb_value : ent_q[qry_id1].value;
  assign qry_val2   = (wb_valid && wb_rob_id == qry_id2) ? wb_value : ent_q[qry_id2].value;

  assign set_value_id     = set_value_id_q;
  assign set_value        = set_value_q;
  assign set_value_rob_id = set_value_rob_id_q;
  assign clear            = clear_q;
  assign clear_pc         = clear_pc_q;

  always_comb begin
    ent_d   = ent_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (rdy_in && wb_valid && busy_q[wb_rob_id]) begin
      ready_d[wb_rob_id]        = 1'b1;
      ent_d[wb_rob_id].value    = wb_value;
      ent_d[wb_rob_id].jump     = wb_jump;
      ent_d[wb_rob_id].target   = wb_target;
    end
    if (do_issue) begin
      ent_d[tail_q]   = '{rd: issue_rd, is_br: issue_is_br, pred_jump: issue_pred_jump,
                          pc: issue_pc, value: '0, jump: 1'b0, target: '0};
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      tail_d          = tail_q + 1'b1;
    end
    if (do_commit) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    count_d = count_q + {{ROB_INDEX_BIT{1'b0}}, do_issue} - {{ROB_INDEX_BIT{1'b0}}, do_commit};
    if (do_flush) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Branches never write a register, so a committing branch drives id 0.
  always_comb begin
    set_value_id_d     = rdy_in ? ((do_commit && !ent_q[head_q].is_br) ? ent_q[head_q].rd : '0) : set_value_id_q;
    set_value_d        = do_commit ? ent_q[head_q].value : set_value_q;
    set_value_rob_id_d = do_commit ? head_q : set_value_rob_id_q;
    clear_d            = rdy_in ? do_flush : clear_q;
    clear_pc_d         = do_flush ? ent_q[head_q].target : clear_pc_q;
  end

  always_ff @(posedge clk_in) ent_q <= ent_d;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q             <= '0;
      ready_q            <= '0;
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      set_value_id_q     <= '0;
      set_value_q        <= '0;
      set_value_rob_id_q <= '0;
      clear_q            <= 1'b0;
      clear_pc_q         <= '0;
    end else begin
      busy_q             <= busy_d;
      ready_q            <= ready_d;
      head_q             <= head_d;
      tail_q             <= tail_d;
      count_q            <= count_d;
      set_value_id_q     <= set_value_id_d;
      set_value_q        <= set_value_d;
      set_value_rob_id_q <= set_value_rob_id_d;
      clear_q            <= clear_d;
      clear_pc_q         <= clear_pc_d;
    end
  end

`ifdef ROB_DBG_COMMIT_EN
  logic        dbg_commit_q, dbg_commit_d;
  logic [31:0] dbg_commit_addr_q, dbg_commit_addr_d;

  assign dbg_commit      = dbg_commit_q;
  assign dbg_commit_addr = dbg_commit_addr_q;

  always_comb begin
    dbg_commit_d      = rdy_in ? do_commit : dbg_commit_q;
    dbg_commit_addr_d = do_commit ? ent_q[head_q].pc : dbg_commit_addr_q;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dbg_commit_q      <= 1'b0;
      dbg_commit_addr_q <= '0;
    end else begin
      dbg_commit_q      <= dbg_commit_d;
      dbg_commit_addr_q <= dbg_commit_addr_d;
    end
  end
`endif
endmodule
